risc_controller: RTL

RISC_CONTROLLER -- requirements
Module: risc_controller

---
 rtl/risc_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/risc_controller.sv
// risc_controller: eight-phase sequencer for a small accumulator CPU.
// Walks INST_ADDR -> ... -> STORE every eight clocks and decodes the
// RAM, IR, AC and PC control strobes from the current phase, the
// latched opcode and the accumulator-zero flag. HLT freezes the
// sequencer in OP_ADDR until reset.
module risc_controller #(
   parameter int unsigned OPCODE_WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    zero,
   output logic                    sel,
   output logic                    rd,
   output logic                    wr,
   output logic                    data_e,
   output logic                    ld_ir,
   output logic                    ld_ac,
   output logic                    inc_pc,
   output logic                    ld_pc,
   output logic                    halt,
   output logic [2:0]              phase
);

   localparam int unsigned PHASE_W = 3;

   // Instruction encodings
   localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(0);
   localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
   localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(3);
   localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(5);
   localparam logic [OPCODE_WIDTH-1:0] OP_STO = OPCODE_WIDTH'(6);
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(7);

   // Phase names; the numeric value is what appears on the phase port
   typedef enum logic [PHASE_W-1:0] {
      PH_INST_ADDR  = PHASE_W'(0),
      PH_INST_FETCH = PHASE_W'(1),
      PH_INST_LOAD  = PHASE_W'(2),
      PH_IDLE       = PHASE_W'(3),
      PH_OP_ADDR    = PHASE_W'(4),
      PH_OP_FETCH   = PHASE_W'(5),
      PH_ALU_OP     = PHASE_W'(6),
      PH_STORE      = PHASE_W'(7)
   } phase_t;

   phase_t phase_q;
   phase_t phase_d;
   logic   halted_q;
   logic   halted_d;

   logic   is_hlt;
   logic   is_skz;
   logic   is_sto;
   logic   is_jmp;
   logic   is_aluop;

   // Opcode class decode shared by several phases
   assign is_hlt   = (opcode == OP_HLT);
   assign is_skz   = (opcode == OP_SKZ);
   assign is_sto   = (opcode == OP_STO);
   assign is_jmp   = (opcode == OP_JMP);
   assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);

   // Phase and halt state; reset is asynchronous so strobes drop at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q  <= PH_INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   // Next phase: free-running 0..7 wrap, frozen at OP_ADDR once halted
   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      if (!halted_q) begin
         unique case (phase_q)
            PH_INST_ADDR:  phase_d = PH_INST_FETCH;
            PH_INST_FETCH: phase_d = PH_INST_LOAD;
            PH_INST_LOAD:  phase_d = PH_IDLE;
            PH_IDLE:       phase_d = PH_OP_ADDR;
            PH_OP_ADDR: begin
               if (is_hlt) begin
                  halted_d = 1'b1;
               end else begin
                  phase_d = PH_OP_FETCH;
               end
            end
            PH_OP_FETCH:   phase_d = PH_ALU_OP;
            PH_ALU_OP:     phase_d = PH_STORE;
            PH_STORE:      phase_d = PH_INST_ADDR;
            default:       phase_d = PH_INST_ADDR;
         endcase
      end
   end

   // Control decode; reset gates every strobe so it acts without a clock
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      ld_ir  = 1'b0;
      ld_ac  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      halt   = 1'b0;
      if (!rst) begin
         if (halted_q) begin
            halt = 1'b1;
         end else begin
            unique case (phase_q)
               PH_INST_ADDR: begin
                  sel = 1'b1;
               end
               PH_INST_FETCH: begin
                  sel = 1'b1;
                  rd  = 1'b1;
               end
               PH_INST_LOAD, PH_IDLE: begin
                  sel   = 1'b1;
                  rd    = 1'b1;
                  ld_ir = 1'b1;
               end
               PH_OP_ADDR: begin
                  inc_pc = 1'b1;
                  halt   = is_hlt;
               end
               PH_OP_FETCH: begin
                  rd = is_aluop;
               end
               PH_ALU_OP: begin
                  rd     = is_aluop;
                  inc_pc = is_skz & zero;
                  ld_pc  = is_jmp;
                  data_e = is_sto;
               end
               PH_STORE: begin
                  rd     = is_aluop;
                  ld_ac  = is_aluop;
                  inc_pc = is_jmp;
                  ld_pc  = is_jmp;
                  wr     = is_sto;
                  data_e = is_sto;
               end
               default: begin
                  sel = 1'b0;
               end
            endcase
         end
      end
   end

   assign phase = phase_q;

endmodule
